// File: rtl/mem_stage_oq.sv
// MEM stage with an in-order outstanding-op queue behind an SRAM-like data bus.
// Loads wait for in-order data_ok; orphaned responses after a flush are drained by a discard counter.
module mem_stage_oq #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_result,
    input  logic        in_req_sent,
    input  logic [3:0]  in_ld,
    input  logic        in_rf_we,
    input  logic [4:0]  in_rf_waddr,
    input  logic        in_exc,
    input  logic        data_ok,
    input  logic [31:0] data_rdata,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        out_rf_we,
    output logic [4:0]  out_rf_waddr,
    output logic [31:0] out_rf_wdata,
    output logic        out_exc,
    input  logic [4:0]  hz_raddr1,
    input  logic [4:0]  hz_raddr2,
    output logic        hz_ld_stall,
    output logic        busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SUM_W = CNT_W + 2;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] wait_q, wait_d;
    logic [DEPTH-1:0] rf_we_q, rf_we_d;
    logic [DEPTH-1:0] exc_q, exc_d;
    logic [31:0]      pc_q     [DEPTH];
    logic [31:0]      pc_d     [DEPTH];
    logic [31:0]      result_q [DEPTH];
    logic [31:0]      result_d [DEPTH];
    logic [31:0]      rdata_q  [DEPTH];
    logic [31:0]      rdata_d  [DEPTH];
    logic [3:0]       ld_q     [DEPTH];
    logic [3:0]       ld_d     [DEPTH];
    logic [4:0]       waddr_q  [DEPTH];
    logic [4:0]       waddr_d  [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             drop;
    logic             route_hit;
    logic [PTR_W-1:0] route_idx;
    logic             head_ready;
    logic [31:0]      head_rdata;
    logic             accept;
    logic             retire;
    logic [SUM_W-1:0] wait_cnt;
    logic [SUM_W-1:0] disc_sum;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // ld = {byte, half, word, sign}; byte has priority if several are set
    function automatic logic [31:0] ld_ext(input logic [3:0] ld, input logic [31:0] res,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (res[1:0])
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = res[1] ? rd[31:16] : rd[15:0];
        if (ld[3]) return {{24{ld[0] & b[7]}}, b};
        if (ld[2]) return {{16{ld[0] & h[15]}}, h};
        if (ld[1]) return rd;
        return res;
    endfunction

    // Response routing: orphans first, otherwise the oldest waiting entry
    always_comb begin
        drop      = data_ok && (discard_q != '0);
        route_hit = 1'b0;
        route_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (data_ok && !drop && !route_hit &&
                valid_q[ptr_add(head_q, i)] && wait_q[ptr_add(head_q, i)]) begin
                route_hit = 1'b1;
                route_idx = ptr_add(head_q, i);
            end
        end
    end

    always_comb begin
        head_ready   = valid_q[head_q] &&
                       (!wait_q[head_q] || (route_hit && (route_idx == head_q)));
        head_rdata   = wait_q[head_q] ? data_rdata : rdata_q[head_q];
        out_valid    = head_ready;
        out_pc       = pc_q[head_q];
        out_rf_we    = head_ready & rf_we_q[head_q];
        out_rf_waddr = waddr_q[head_q];
        out_rf_wdata = ld_ext(ld_q[head_q], result_q[head_q], head_rdata);
        out_exc      = valid_q[head_q] & exc_q[head_q];
        in_ready     = (occ_q < CNT_W'(DEPTH)) && !flush;
        busy         = (occ_q != '0) || (discard_q != '0);
        hz_ld_stall  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && wait_q[i] && (ld_q[i] != 4'd0) && rf_we_q[i] &&
                (waddr_q[i] != 5'd0) &&
                ((waddr_q[i] == hz_raddr1) || (waddr_q[i] == hz_raddr2)))
                hz_ld_stall = 1'b1;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        wait_d    = wait_q;
        rf_we_d   = rf_we_q;
        exc_d     = exc_q;
        pc_d      = pc_q;
        result_d  = result_q;
        rdata_d   = rdata_q;
        ld_d      = ld_q;
        waddr_d   = waddr_q;
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        discard_d = discard_q;
        accept    = in_valid && in_ready;
        retire    = head_ready && out_ready;
        wait_cnt  = '0;
        for (int i = 0; i < DEPTH; i++)
            wait_cnt = wait_cnt + SUM_W'(valid_q[i] & wait_q[i]);
        // Every request the bus still owes us becomes an orphan on flush
        disc_sum = SUM_W'(discard_q) + wait_cnt + SUM_W'(in_valid && in_req_sent);
        if (data_ok && (disc_sum != '0))
            disc_sum = disc_sum - SUM_W'(1);

        if (flush) begin
            valid_d   = '0;
            wait_d    = '0;
            head_d    = '0;
            tail_d    = '0;
            occ_d     = '0;
            discard_d = CNT_W'(disc_sum);
        end else begin
            if (drop) begin
                discard_d = discard_q - CNT_W'(1);
            end else if (route_hit) begin
                wait_d[route_idx]  = 1'b0;
                rdata_d[route_idx] = data_rdata;
            end
            if (retire) begin
                valid_d[head_q] = 1'b0;
                head_d          = ptr_inc(head_q);
            end
            if (accept) begin
                valid_d[tail_q]  = 1'b1;
                wait_d[tail_q]   = in_req_sent & ~in_exc;
                rf_we_d[tail_q]  = in_rf_we;
                exc_d[tail_q]    = in_exc;
                pc_d[tail_q]     = in_pc;
                result_d[tail_q] = in_result;
                ld_d[tail_q]     = in_ld;
                waddr_d[tail_q]  = in_rf_waddr;
                rdata_d[tail_q]  = 32'd0;
                tail_d           = ptr_inc(tail_q);
            end
            occ_d = occ_q + CNT_W'(accept) - CNT_W'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q   <= '0;
            wait_q    <= '0;
            rf_we_q   <= '0;
            exc_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            discard_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                result_q[i] <= '0;
                rdata_q[i]  <= '0;
                ld_q[i]     <= '0;
                waddr_q[i]  <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            wait_q    <= wait_d;
            rf_we_q   <= rf_we_d;
            exc_q     <= exc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            discard_q <= discard_d;
            pc_q      <= pc_d;
            result_q  <= result_d;
            rdata_q   <= rdata_d;
            ld_q      <= ld_d;
            waddr_q   <= waddr_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_oq.sv
// Bench for mem_stage_oq: directed scenarios plus random traffic against a queue-based
// reference model that also plays the in-order data bus.
module tb_mem_stage_oq;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_result;
    logic        in_req_sent;
    logic [3:0]  in_ld;
    logic        in_rf_we;
    logic [4:0]  in_rf_waddr;
    logic        in_exc;
    logic        data_ok;
    logic [31:0] data_rdata;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc;
    logic        out_rf_we;
    logic [4:0]  out_rf_waddr;
    logic [31:0] out_rf_wdata;
    logic        out_exc;
    logic [4:0]  hz_raddr1, hz_raddr2;
    logic        hz_ld_stall;
    logic        busy;

    always #5 clk = ~clk;

    mem_stage_oq #(.DEPTH(DEPTH), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_result(in_result),
        .in_req_sent(in_req_sent), .in_ld(in_ld), .in_rf_we(in_rf_we),
        .in_rf_waddr(in_rf_waddr), .in_exc(in_exc),
        .data_ok(data_ok), .data_rdata(data_rdata), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
        .out_exc(out_exc), .hz_raddr1(hz_raddr1), .hz_raddr2(hz_raddr2),
        .hz_ld_stall(hz_ld_stall), .busy(busy)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic [3:0]  ld;
        logic        we;
        logic [4:0]  wa;
        logic        exc;
        logic        wt;
        logic [31:0] rd;
    } ent_t;

    ent_t mq[$];
    int   mdisc;
    int   n_checks = 0;
    int   n_pass = 0;
    logic        obs_ready, obs_valid, obs_stall, obs_exc, obs_busy;
    logic [31:0] obs_wdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] ref_ext(input ent_t e, input logic [31:0] rd);
        logic [31:0] v;
        if (e.ld[3]) begin
            v = (rd >> (8 * e.result[1:0])) & 32'hFF;
            if (e.ld[0] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (e.ld[2]) begin
            v = (rd >> (16 * e.result[1])) & 32'hFFFF;
            if (e.ld[0] && v[15]) v = v | 32'hFFFF_0000;
        end else if (e.ld[1]) begin
            v = rd;
        end else begin
            v = e.result;
        end
        return v;
    endfunction

    function automatic int mwaiters();
        int n = 0;
        foreach (mq[i]) if (mq[i].wt) n++;
        return n;
    endfunction

    // One clock: check outputs at negedge against the model, advance the model at posedge
    task automatic cyc();
        int   route;
        bit   drop, hv, ev, es, er, acc;
        logic [31:0] ew;
        ent_t e;
        @(negedge clk);
        route = -1;
        drop  = data_ok && (mdisc > 0);
        if (data_ok && !drop)
            foreach (mq[i]) if (route < 0 && mq[i].wt) route = i;
        hv = mq.size() > 0;
        ev = hv && (!mq[0].wt || route == 0);
        er = (mq.size() < DEPTH) && !flush;
        ew = 32'd0;
        if (ev) ew = ref_ext(mq[0], mq[0].wt ? data_rdata : mq[0].rd);
        es = 0;
        foreach (mq[i])
            if (mq[i].wt && mq[i].ld != 4'd0 && mq[i].we && mq[i].wa != 5'd0 &&
                (mq[i].wa == hz_raddr1 || mq[i].wa == hz_raddr2)) es = 1;
        check_eq("in_ready", in_ready, er);
        check_eq("out_valid", out_valid, ev);
        check_eq("out_rf_we", out_rf_we, ev && mq[0].we);
        check_eq("out_exc", out_exc, hv && mq[0].exc);
        check_eq("hz_ld_stall", hz_ld_stall, es);
        check_eq("busy", busy, (mq.size() != 0) || (mdisc != 0));
        if (ev) begin
            check_eq("out_pc", out_pc, mq[0].pc);
            check_eq("out_rf_waddr", out_rf_waddr, mq[0].wa);
            check_eq("out_rf_wdata", out_rf_wdata, ew);
        end
        obs_ready = in_ready; obs_valid = out_valid; obs_stall = hz_ld_stall;
        obs_exc = out_exc; obs_busy = busy; obs_wdata = out_rf_wdata;
        acc = in_valid && er;
        @(posedge clk);
        if (!resetn) begin
            mq.delete();
            mdisc = 0;
        end else if (flush) begin
            mdisc = mdisc + mwaiters() + ((in_valid && in_req_sent) ? 1 : 0) - (data_ok ? 1 : 0);
            if (mdisc < 0) mdisc = 0;
            mq.delete();
        end else begin
            if (drop) mdisc--;
            else if (route >= 0) begin
                e = mq[route]; e.wt = 0; e.rd = data_rdata; mq[route] = e;
            end
            if (ev && out_ready) void'(mq.pop_front());
            if (acc) begin
                e.pc = in_pc; e.result = in_result; e.ld = in_ld; e.we = in_rf_we;
                e.wa = in_rf_waddr; e.exc = in_exc; e.wt = in_req_sent && !in_exc; e.rd = 32'd0;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        resetn = 1; in_valid = 0; in_pc = 0; in_result = 0; in_req_sent = 0; in_ld = 0;
        in_rf_we = 0; in_rf_waddr = 0; in_exc = 0; data_ok = 0; data_rdata = 0;
        flush = 0; out_ready = 1; hz_raddr1 = 0; hz_raddr2 = 0;
    endtask

    task automatic issue_ld(input logic [3:0] ld, input logic [31:0] addr, input logic [4:0] wa);
        idle();
        in_valid = 1; in_req_sent = 1; in_ld = ld; in_rf_we = 1; in_rf_waddr = wa;
        in_result = addr; in_pc = 32'h1c00_0000 + addr;
    endtask

    task automatic resp(input logic [31:0] rd);
        idle();
        data_ok = 1; data_rdata = rd;
    endtask

    task automatic rand_inputs();
        int outst, kind, sel;
        outst = mdisc + mwaiters();
        idle();
        kind = $urandom_range(0, 9);
        if (outst >= 3 && kind < 7) kind = 7;
        in_valid = ($urandom_range(0, 99) < 60);
        in_pc = $urandom; in_result = $urandom; in_rf_waddr = 5'($urandom_range(0, 7));
        if (kind < 4) begin
            sel = $urandom_range(0, 2);
            in_req_sent = 1; in_rf_we = 1'($urandom_range(0, 1));
            in_ld = {sel == 0, sel == 1, sel == 2, 1'($urandom_range(0, 1))};
        end else if (kind < 6) begin
            in_req_sent = 1;
        end else if (kind < 9) begin
            in_rf_we = 1'($urandom_range(0, 1));
        end else begin
            in_exc = 1;
        end
        data_ok    = (outst > 0) && ($urandom_range(0, 2) == 0);
        data_rdata = $urandom;
        flush      = ($urandom_range(0, 31) == 0);
        out_ready  = ($urandom_range(0, 3) != 0);
        hz_raddr1  = 5'($urandom_range(0, 7));
        hz_raddr2  = 5'($urandom_range(0, 7));
        resetn     = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        idle();
        resetn = 0;
        mdisc = 0;
        repeat (2) @(posedge clk);
        #1;
        idle();
        cyc();
        check_eq("rst_ready", obs_ready, 1);
        check_eq("rst_busy", obs_busy, 0);

        // ld.w, response the next cycle, bypassed to WB
        issue_ld(4'b0010, 32'h100, 5'd3); cyc();
        check_eq("t1_acc_valid", obs_valid, 0);
        resp(32'h8765_4321); cyc();
        check_eq("t1_valid", obs_valid, 1);
        check_eq("t1_wdata", obs_wdata, 32'h8765_4321);
        idle(); cyc();
        check_eq("t1_busy", obs_busy, 0);

        // ld.b signed and ld.hu
        issue_ld(4'b1001, 32'h103, 5'd4); cyc();
        resp(32'h8012_3456); cyc();
        check_eq("t2_ldb", obs_wdata, 32'hFFFF_FF80);
        issue_ld(4'b0100, 32'h102, 5'd4); cyc();
        resp(32'hBEEF_0000); cyc();
        check_eq("t2_ldhu", obs_wdata, 32'h0000_BEEF);

        // full queue, delayed responses, WB back-pressure
        issue_ld(4'b0010, 32'h200, 5'd6); cyc();
        issue_ld(4'b0010, 32'h204, 5'd7); cyc();
        idle(); cyc();
        check_eq("t3_full", obs_ready, 0);
        resp(32'hAAAA_0001); out_ready = 0; cyc();
        resp(32'hBBBB_0002); out_ready = 0; cyc();
        check_eq("t3_hold", obs_wdata, 32'hAAAA_0001);
        idle(); cyc();
        check_eq("t3_first", obs_wdata, 32'hAAAA_0001);
        idle(); cyc();
        check_eq("t3_second", obs_wdata, 32'hBBBB_0002);

        // flush with two pending loads: two orphans drained before the new load
        issue_ld(4'b0010, 32'h300, 5'd8); cyc();
        issue_ld(4'b0010, 32'h304, 5'd9); cyc();
        idle(); flush = 1; cyc();
        issue_ld(4'b0010, 32'h308, 5'd10); cyc();
        check_eq("t4_acc_during_discard", obs_busy, 1);
        resp(32'h1111_1111); cyc();
        check_eq("t4_drop1", obs_valid, 0);
        resp(32'h2222_2222); cyc();
        check_eq("t4_drop2", obs_valid, 0);
        resp(32'h3333_3333); cyc();
        check_eq("t4_deliver", obs_wdata, 32'h3333_3333);
        idle(); cyc();
        check_eq("t4_busy", obs_busy, 0);

        // load-use hazard
        issue_ld(4'b0010, 32'h400, 5'd5); cyc();
        idle(); hz_raddr1 = 5; cyc();
        check_eq("t5_stall", obs_stall, 1);
        resp(32'h5); hz_raddr1 = 5; cyc();
        idle(); hz_raddr1 = 5; cyc();
        check_eq("t5_clear", obs_stall, 0);
        issue_ld(4'b0010, 32'h404, 5'd0); cyc();
        idle(); cyc();
        check_eq("t5_r0", obs_stall, 0);
        resp(32'h6); cyc();

        // exception op, then reset while a load waits
        idle(); in_valid = 1; in_exc = 1; in_pc = 32'h1c00_0500; cyc();
        idle(); cyc();
        check_eq("t6_exc", obs_exc, 1);
        check_eq("t6_valid", obs_valid, 1);
        issue_ld(4'b0010, 32'h500, 5'd2); cyc();
        idle(); resetn = 0; cyc();
        idle(); cyc();
        check_eq("t6_rst_busy", obs_busy, 0);
        check_eq("t6_rst_ready", obs_ready, 1);
        check_eq("t6_rst_valid", obs_valid, 0);

        repeat (4000) begin
            rand_inputs();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
